adjacency_builder: RTL and testbench

Builds the flattened N×N adjacency matrix that the clique-finding datapath consumes, from a streamed list of edges. It is the writer-side counterpart of the edge-enumeration stage: edge-enumeration turns a matrix into vertex pairs, and this block turns vertex pairs back into a matrix. It sits between the host/testbench edge source and the combination/clique stages. Edges arrive one per cycle over a valid/ready handshake. A done flag marks the moment the matrix is complete and stable.

---
 rtl/adjb_pkg.sv | 28 ++
 rtl/adjacency_builder_if.sv | 24 ++
 rtl/adjb_edge_check.sv | 31 +++
 rtl/adjacency_builder.sv | 133 +++++++++++++
 tb/tb_adjacency_builder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/adjb_pkg.sv
// Shared types and sizing for the adjacency matrix builder.
// Optional feature macro: ADJB_SYMMETRIC_EN (mirror every edge into [v][u]).
package adjb_pkg;

  localparam int unsigned N_VERT_DEF    = 5;
  localparam int unsigned MAX_EDGES_DEF = 10;

  // Vertex index width; at least one bit even for a single-vertex graph.
  function automatic int unsigned vidx_w(input int unsigned n_vert);
    return (n_vert > 1) ? $clog2(n_vert) : 1;
  endfunction

  // Edge counter width, wide enough to hold max_edges itself.
  function automatic int unsigned cnt_w(input int unsigned max_edges);
    return $clog2(max_edges + 1);
  endfunction

  localparam int unsigned VIDX_W_DEF = vidx_w(N_VERT_DEF);
  localparam int unsigned CNT_W_DEF  = cnt_w(MAX_EDGES_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } adjb_state_e;

endpackage

// File: rtl/adjacency_builder_if.sv
// Edge stream handshake: source drives an edge, builder returns ready.
interface adjacency_builder_if
  import adjb_pkg::*;
#(
  parameter int unsigned VIDX_W = VIDX_W_DEF
);

  logic              edge_valid;
  logic              edge_ready;
  logic [VIDX_W-1:0] edge_u;
  logic [VIDX_W-1:0] edge_v;
  logic              edge_last;

  modport master (
    output edge_valid, edge_u, edge_v, edge_last,
    input  edge_ready
  );

  modport slave (
    input  edge_valid, edge_u, edge_v, edge_last,
    output edge_ready
  );

endinterface

// File: rtl/adjb_edge_check.sv
// Classifies an incoming edge against the current matrix: validity,
// linear bit positions of [u][v] and its mirror, and whether [u][v] is set.
module adjb_edge_check
  import adjb_pkg::*;
#(
  parameter  int unsigned N_VERT = N_VERT_DEF,
  parameter  int unsigned VIDX_W = VIDX_W_DEF,
  localparam int unsigned NN     = N_VERT * N_VERT,
  localparam int unsigned IDX_W  = $clog2(NN)
) (
  input  logic [VIDX_W-1:0] edge_u,
  input  logic [VIDX_W-1:0] edge_v,
  input  logic [NN-1:0]     flat_array,
  output logic              is_valid_c,
  output logic [IDX_W-1:0]  bit_idx_c,
  output logic [IDX_W-1:0]  mir_idx_c,
  output logic              is_duplicate_c
);

  // Self-loops and out-of-range vertices are rejected; indices are only
  // meaningful when the edge is valid.
  always_comb begin
    is_valid_c     = (edge_u != edge_v) &&
                     (32'(edge_u) < N_VERT) &&
                     (32'(edge_v) < N_VERT);
    bit_idx_c      = IDX_W'(32'(edge_u) * N_VERT + 32'(edge_v));
    mir_idx_c      = IDX_W'(32'(edge_v) * N_VERT + 32'(edge_u));
    is_duplicate_c = is_valid_c && flat_array[bit_idx_c];
  end

endmodule

// File: rtl/adjacency_builder.sv
// Builds the flattened N_VERT x N_VERT adjacency matrix from a stream of
// edges. Optional macro ADJB_SYMMETRIC_EN: each edge also sets its mirror bit.
module adjacency_builder
  import adjb_pkg::*;
#(
  parameter int unsigned N_VERT    = N_VERT_DEF,
  parameter int unsigned MAX_EDGES = MAX_EDGES_DEF,
  parameter int unsigned VIDX_W    = vidx_w(N_VERT),
  parameter int unsigned CNT_W     = cnt_w(MAX_EDGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  adjacency_builder_if.slave         bus,
  output logic [N_VERT*N_VERT-1:0]   flatArray,
  output logic [CNT_W-1:0]           edge_count,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned NN    = N_VERT * N_VERT;
  localparam int unsigned IDX_W = $clog2(NN);

  adjb_state_e      state;
  logic             ready_q;
  logic             accept_c;
  logic             is_valid_c;
  logic             is_duplicate_c;
  logic [IDX_W-1:0] bit_idx_c;
  logic [IDX_W-1:0] mir_idx_c;
  logic [NN-1:0]    set_mask_c;
  logic             fills_c;
  logic             finish_c;

  assign bus.edge_ready = ready_q;

  adjb_edge_check #(
    .N_VERT (N_VERT),
    .VIDX_W (VIDX_W)
  ) u_edge_check (
    .edge_u         (bus.edge_u),
    .edge_v         (bus.edge_v),
    .flat_array     (flatArray),
    .is_valid_c     (is_valid_c),
    .bit_idx_c      (bit_idx_c),
    .mir_idx_c      (mir_idx_c),
    .is_duplicate_c (is_duplicate_c)
  );

  // Bits to OR into the matrix for the current edge.
`ifdef ADJB_SYMMETRIC_EN
  assign set_mask_c = (NN'(1) << bit_idx_c) | (NN'(1) << mir_idx_c);
`else
  logic unused_mir_c;
  assign unused_mir_c = ^mir_idx_c;
  assign set_mask_c   = NN'(1) << bit_idx_c;
`endif

  // Accept decode and load termination: explicit last, or capacity reached.
  always_comb begin
    accept_c = bus.edge_valid && ready_q;
    fills_c  = is_valid_c && !is_duplicate_c &&
               (edge_count == CNT_W'(MAX_EDGES - 1));
    finish_c = bus.edge_last || fills_c;
  end

  // Control FSM with matrix, counter and flags; clearing happens on entry to
  // CLEAR so the matrix already reads zero during that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_q    <= 1'b0;
      flatArray  <= '0;
      edge_count <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CLEAR;
            flatArray  <= '0;
            edge_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
          end
        end
        CLEAR: begin
          state   <= LOAD;
          ready_q <= 1'b1;
        end
        LOAD: begin
          if (start) begin
            state      <= CLEAR;
            ready_q    <= 1'b0;
            flatArray  <= '0;
            edge_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
          end else if (accept_c) begin
            if (!is_valid_c) begin
              err <= 1'b1;
            end else begin
              flatArray <= flatArray | set_mask_c;
              if (!is_duplicate_c) begin
                edge_count <= edge_count + CNT_W'(1);
              end
            end
            if (finish_c) begin
              state   <= DONE;
              ready_q <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state      <= CLEAR;
            flatArray  <= '0;
            edge_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adjacency_builder.sv
// Directed self-checking bench for adjacency_builder (5 vertices).
module tb_adjacency_builder;

  localparam int unsigned N_VERT = 5;

  // Expected matrices; bit [i*5+j] is edge i->j.
`ifdef ADJB_SYMMETRIC_EN
  localparam logic [24:0] EXP_BASIC = 25'h04048A2; // bits 1,5,7,11,14,22
  localparam logic [24:0] EXP_ERR   = 25'h0000404; // bits 2,10
  localparam logic [3:0]  EXP_DUPC  = 4'd1;
  localparam logic [24:0] EXP_K5    = 25'h0FBEFBE; // full matrix minus diagonal
  localparam logic [24:0] EXP_ABORT = 25'h0880000; // bits 19,23
`else
  localparam logic [24:0] EXP_BASIC = 25'h0004082; // bits 1,7,14
  localparam logic [24:0] EXP_ERR   = 25'h0000004; // bit 2
  localparam logic [3:0]  EXP_DUPC  = 4'd2;
  localparam logic [24:0] EXP_K5    = 25'h008639E; // upper triangle only
  localparam logic [24:0] EXP_ABORT = 25'h0080000; // bit 19
`endif
  localparam logic [24:0] EXP_DUPM  = 25'h0000880; // bits 7,11

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [24:0] flat;
  logic [3:0]  edge_count;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;

  adjacency_builder_if #(.VIDX_W(3)) bus ();

  adjacency_builder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .flatArray  (flat),
    .edge_count (edge_count),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one edge for exactly one cycle.
  task automatic send(input logic [2:0] u, input logic [2:0] v, input logic last);
    bus.edge_valid = 1'b1;
    bus.edge_u     = u;
    bus.edge_v     = v;
    bus.edge_last  = last;
    @(negedge clk);
    bus.edge_valid = 1'b0;
    bus.edge_last  = 1'b0;
  endtask

  // Called at a negedge; pulses start, checks the CLEAR cycle, ends in LOAD.
  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_clear_flat"},  32'(flat), 32'h0);
    chk({tag, "_clear_ready"}, 32'(bus.edge_ready), 32'h0);
    chk({tag, "_clear_done"},  32'(done), 32'h0);
    @(negedge clk);
    chk({tag, "_load_ready"},  32'(bus.edge_ready), 32'h1);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.edge_valid = 1'b0;
    bus.edge_u     = 3'd0;
    bus.edge_v     = 3'd0;
    bus.edge_last  = 1'b0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_flat",  32'(flat), 32'h0);
    chk("rst_count", 32'(edge_count), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_ready", 32'(bus.edge_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", 32'(bus.edge_ready), 32'h0);

    // Basic load of three edges
    do_start("t1");
    send(3'd0, 3'd1, 1'b0);
    send(3'd1, 3'd2, 1'b0);
    chk("t1_done_early", 32'(done), 32'h0);
    chk("t1_count_mid",  32'(edge_count), 32'h2);
    send(3'd2, 3'd4, 1'b1);
    chk("t1_flat",  32'(flat), 32'(EXP_BASIC));
    chk("t1_count", 32'(edge_count), 32'h3);
    chk("t1_done",  32'(done), 32'h1);
    chk("t1_ready", 32'(bus.edge_ready), 32'h0);
    chk("t1_err",   32'(err), 32'h0);
    @(negedge clk);
    chk("t1_done_held", 32'(done), 32'h1);
    chk("t1_flat_held", 32'(flat), 32'(EXP_BASIC));

    // Invalid edges set err and leave the matrix alone
    do_start("t2");
    send(3'd3, 3'd3, 1'b0);
    chk("t2_err_self", 32'(err), 32'h1);
    chk("t2_flat_self", 32'(flat), 32'h0);
    send(3'd0, 3'd7, 1'b0);
    send(3'd0, 3'd2, 1'b1);
    chk("t2_err",   32'(err), 32'h1);
    chk("t2_flat",  32'(flat), 32'(EXP_ERR));
    chk("t2_count", 32'(edge_count), 32'h1);
    chk("t2_done",  32'(done), 32'h1);

    // Duplicates and reversed pairs; err cleared by the new start
    do_start("t3");
    chk("t3_err_cleared", 32'(err), 32'h0);
    send(3'd1, 3'd2, 1'b0);
    send(3'd2, 3'd1, 1'b0);
    send(3'd1, 3'd2, 1'b1);
    chk("t3_count", 32'(edge_count), 32'(EXP_DUPC));
    chk("t3_flat",  32'(flat), 32'(EXP_DUPM));
    chk("t3_err",   32'(err), 32'h0);

    // Invalid edge carrying last still terminates the load
    do_start("t4");
    send(3'd4, 3'd4, 1'b1);
    chk("t4_done",  32'(done), 32'h1);
    chk("t4_err",   32'(err), 32'h1);
    chk("t4_count", 32'(edge_count), 32'h0);
    chk("t4_flat",  32'(flat), 32'h0);

    // All ten K5 pairs without last: capacity ends the load
    do_start("t5");
    send(3'd0, 3'd1, 1'b0);
    send(3'd0, 3'd2, 1'b0);
    send(3'd0, 3'd3, 1'b0);
    send(3'd0, 3'd4, 1'b0);
    send(3'd1, 3'd2, 1'b0);
    send(3'd1, 3'd3, 1'b0);
    send(3'd1, 3'd4, 1'b0);
    send(3'd2, 3'd3, 1'b0);
    send(3'd2, 3'd4, 1'b0);
    chk("t5_done_9",  32'(done), 32'h0);
    chk("t5_ready_9", 32'(bus.edge_ready), 32'h1);
    send(3'd3, 3'd4, 1'b0);
    chk("t5_done",  32'(done), 32'h1);
    chk("t5_ready", 32'(bus.edge_ready), 32'h0);
    chk("t5_count", 32'(edge_count), 32'd10);
    chk("t5_flat",  32'(flat), 32'(EXP_K5));

    // Start mid-load alongside a valid edge: edge dropped, load restarts clean
    do_start("t6");
    send(3'd0, 3'd1, 1'b0);
    send(3'd1, 3'd2, 1'b0);
    chk("t6_count_pre", 32'(edge_count), 32'h2);
    start          = 1'b1;
    bus.edge_valid = 1'b1;
    bus.edge_u     = 3'd0;
    bus.edge_v     = 3'd3;
    @(negedge clk);
    start          = 1'b0;
    bus.edge_valid = 1'b0;
    chk("t6_clear_flat",  32'(flat), 32'h0);
    chk("t6_clear_count", 32'(edge_count), 32'h0);
    chk("t6_clear_ready", 32'(bus.edge_ready), 32'h0);
    @(negedge clk);
    chk("t6_load_ready", 32'(bus.edge_ready), 32'h1);
    send(3'd3, 3'd4, 1'b1);
    chk("t6_flat",  32'(flat), 32'(EXP_ABORT));
    chk("t6_count", 32'(edge_count), 32'h1);
    chk("t6_done",  32'(done), 32'h1);

    // Asynchronous reset mid-load
    do_start("t7");
    send(3'd0, 3'd1, 1'b0);
    send(3'd2, 3'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_flat",  32'(flat), 32'h0);
    chk("t7_rst_count", 32'(edge_count), 32'h0);
    chk("t7_rst_ready", 32'(bus.edge_ready), 32'h0);
    chk("t7_rst_done",  32'(done), 32'h0);
    chk("t7_rst_err",   32'(err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t7_idle_ready", 32'(bus.edge_ready), 32'h0);
    chk("t7_idle_done",  32'(done), 32'h0);
    do_start("t8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
